// File: rtl/dff_mem_pkg.sv
// dff_mem_pkg: shared state type, requester ids and default widths for the DFF RAM arbiter
package dff_mem_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
endpackage

// File: rtl/dff_mem_arbiter_if.sv
// dff_mem_arbiter_if: requester handshake, response and RAM command bundle
interface dff_mem_arbiter_if
  import dff_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic [1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [ADDR_W-1:0] req_addr_a, req_addr_b, mem_addr;
  logic [DATA_W-1:0] req_wdata_a, req_wdata_b, rsp_rdata, mem_wdata, mem_rdata;
  logic busy, mem_we, mem_re;
  modport master (
    output req_valid, req_we, req_addr_a, req_addr_b, req_wdata_a, req_wdata_b, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
  modport slave (
    input  req_valid, req_we, req_addr_a, req_addr_b, req_wdata_a, req_wdata_b, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/dff_mem_rr_arb.sv
// dff_mem_rr_arb: two-way round-robin grant with a registered last-winner pointer
module dff_mem_rr_arb
  import dff_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_accept,
  output logic [1:0] o_grant
);
  logic r_last, w_win;
  // a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    w_win = (i_valid == 2'b11) ? ~r_last : i_valid[1];
    o_grant = (|i_valid) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  end
  // pointer moves only when the grant is actually taken
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= REQ_B;
    else if (i_accept) r_last <= w_win;
endmodule

// File: rtl/dff_mem_arbiter.sv
// dff_mem_arbiter: round-robin sharing of the single-port DFF scratch RAM between two requesters
module dff_mem_arbiter
  import dff_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic rst_n,
  dff_mem_arbiter_if.slave bus
);
  state_t r_state, w_state_nx;
  logic r_id, r_we, r_mem_we, r_mem_re;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [1:0] r_rsp_valid, w_grant, w_ready;
  logic w_hs, w_sel, w_req_we, w_done;

  dff_mem_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (bus.req_valid),
    .i_accept(w_hs),
    .o_grant (w_grant)
  );

  assign w_ready  = (rst_n && r_state == IDLE) ? w_grant : 2'b00;
  assign w_hs     = |(bus.req_valid & w_ready);
  assign w_sel    = w_ready[1];
  assign w_req_we = bus.req_we[w_sel];
  assign w_done   = (r_state == ISSUE && r_we) || r_state == RDWAIT;

  // accept in IDLE, strobe the RAM for one cycle, reads spend one more cycle collecting data
  always_comb begin
    w_state_nx = IDLE;
    if (r_state == IDLE) w_state_nx = w_hs ? ISSUE : IDLE;
    else if (r_state == ISSUE) w_state_nx = r_we ? IDLE : RDWAIT;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;

  // latch the accepted request; the strobes are registered so they land in the ISSUE cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_id     <= REQ_A;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
    end else begin
      r_mem_we <= w_hs & w_req_we;
      r_mem_re <= w_hs & ~w_req_we;
      if (w_hs) begin
        r_id    <= w_sel;
        r_we    <= w_req_we;
        r_addr  <= w_sel ? bus.req_addr_b : bus.req_addr_a;
        r_wdata <= w_sel ? bus.req_wdata_b : bus.req_wdata_a;
      end
    end

  // completion pulse to the owner; read data captured from the RAM in RDWAIT
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rsp_valid <= 2'b00;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= {w_done & r_id, w_done & ~r_id};
      if (r_state == RDWAIT) r_rdata <= bus.mem_rdata;
    end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.busy      = (r_state != IDLE);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
endmodule

// File: tb/tb_dff_mem_arbiter.sv
// tb_dff_mem_arbiter: directed vector table, corner sequences and random traffic against a schedule model
`timescale 1ns/1ps
module tb_dff_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dff_mem_arbiter_if bus ();
  dff_mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // RAM macro stand-in: registered read, data valid the cycle after mem_re
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
  end

  typedef struct packed {logic we; logic re; logic [3:0] addr; logic [7:0] wdata;} strobe_t;
  typedef struct {
    logic [1:0] vld, we;
    logic [3:0] aa, ab;
    logic [7:0] da, db;
    logic [1:0] rdy, rsp;
    bit chk_rd;
    logic [7:0] rd;
  } vec_t;

  int n_tests = 0, n_fail = 0, cyc = 0, free_at = 0;
  bit last = 1'b1;
  logic [7:0] mref [16];
  strobe_t exp_strobe [int];
  logic [1:0] exp_rsp [int];
  logic [7:0] exp_rd [int];
  logic [1:0] ob_rdy, ob_rsp;
  logic [7:0] ob_rd;
  vec_t tbl [24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_strobe.delete();
    exp_rsp.delete();
    exp_rd.delete();
    last = 1'b1;
    free_at = cyc;
  endtask

  // one cycle: drive, compare against the scheduled expectations, book any new acceptance
  task automatic tick(input logic [1:0] vld, input logic [1:0] we, input logic [3:0] aa,
                      input logic [3:0] ab, input logic [7:0] da, input logic [7:0] db);
    logic [1:0] e_rdy;
    bit win, w;
    logic [3:0] a;
    logic [7:0] d;
    strobe_t s;
    int lat;
    bus.req_valid = vld;
    bus.req_we = we;
    bus.req_addr_a = aa;
    bus.req_addr_b = ab;
    bus.req_wdata_a = da;
    bus.req_wdata_b = db;
    #1;
    ob_rdy = bus.req_ready;
    ob_rsp = bus.rsp_valid;
    ob_rd = bus.rsp_rdata;
    win = (vld == 2'b11) ? ~last : vld[1];
    e_rdy = (cyc >= free_at && vld != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
    s = exp_strobe.exists(cyc) ? exp_strobe[cyc] : '0;
    chk("req_ready", 32'(ob_rdy), 32'(e_rdy));
    chk("rsp_valid", 32'(ob_rsp), 32'(exp_rsp.exists(cyc) ? exp_rsp[cyc] : 2'b00));
    if (exp_rd.exists(cyc)) chk("rsp_rdata", 32'(ob_rd), 32'(exp_rd[cyc]));
    chk("mem_we", 32'(bus.mem_we), 32'(s.we));
    chk("mem_re", 32'(bus.mem_re), 32'(s.re));
    if (s.we || s.re) chk("mem_addr", 32'(bus.mem_addr), 32'(s.addr));
    if (s.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(s.wdata));
    chk("busy", 32'(bus.busy), 32'(cyc < free_at));
    if (e_rdy != 2'b00) begin
      w = we[win];
      a = win ? ab : aa;
      d = win ? db : da;
      lat = w ? 2 : 3;
      last = win;
      free_at = cyc + lat;
      exp_strobe[cyc + 1] = {w, ~w, a, d};
      exp_rsp[cyc + lat] = win ? 2'b10 : 2'b01;
      if (w) mref[a] = d;
      else exp_rd[cyc + lat] = mref[a];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [1:0] pv, pwe, exp_g;
  logic [3:0] pa [2];
  logic [7:0] pd [2];

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'h00;
      mref[i] = 8'h00;
    end
    bus.req_valid = 2'b11;
    bus.req_we = 2'b00;
    bus.req_addr_a = 4'h0;
    bus.req_addr_b = 4'h0;
    bus.req_wdata_a = 8'h00;
    bus.req_wdata_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'(2'b00));
    chk("rst_rsp", 32'(bus.rsp_valid), 32'(2'b00));
    chk("rst_we", 32'(bus.mem_we), 32'(1'b0));
    chk("rst_re", 32'(bus.mem_re), 32'(1'b0));
    chk("rst_busy", 32'(bus.busy), 32'(1'b0));
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'(8'h00));
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    model_reset();

    // vld, we, addr_a, addr_b, wdata_a, wdata_b, ready, rsp, check rdata, rdata
    tbl[0]  = '{2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00, 2'b01, 2'b00, 0, 8'h00};
    tbl[1]  = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[2]  = '{2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00, 2'b01, 2'b01, 0, 8'h00};
    tbl[3]  = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[4]  = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[5]  = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b01, 1, 8'hA5};
    tbl[6]  = '{2'b10, 2'b10, 4'h0, 4'hF, 8'h00, 8'h5A, 2'b10, 2'b00, 0, 8'h00};
    tbl[7]  = '{2'b01, 2'b00, 4'hF, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[8]  = '{2'b01, 2'b00, 4'hF, 4'h0, 8'h00, 8'h00, 2'b01, 2'b10, 0, 8'h00};
    tbl[9]  = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[10] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[11] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b01, 1, 8'h5A};
    tbl[12] = '{2'b01, 2'b01, 4'h0, 4'h0, 8'h01, 8'h00, 2'b01, 2'b00, 0, 8'h00};
    tbl[13] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[14] = '{2'b10, 2'b10, 4'h0, 4'hF, 8'h00, 8'hFF, 2'b10, 2'b01, 0, 8'h00};
    tbl[15] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[16] = '{2'b01, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b01, 2'b10, 0, 8'h00};
    tbl[17] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[18] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[19] = '{2'b10, 2'b00, 4'h0, 4'hF, 8'h00, 8'h00, 2'b10, 2'b01, 1, 8'h01};
    tbl[20] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[21] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    tbl[22] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b10, 1, 8'hFF};
    tbl[23] = '{2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00};
    foreach (tbl[i]) begin
      tick(tbl[i].vld, tbl[i].we, tbl[i].aa, tbl[i].ab, tbl[i].da, tbl[i].db);
      chk("tbl_ready", 32'(ob_rdy), 32'(tbl[i].rdy));
      chk("tbl_rsp", 32'(ob_rsp), 32'(tbl[i].rsp));
      if (tbl[i].chk_rd) chk("tbl_rdata", 32'(ob_rd), 32'(tbl[i].rd));
    end

    // tie: both keep reading, grants must alternate starting with A
    exp_g = 2'b01;
    for (int k = 0; k < 12; k++) begin
      tick(2'b11, 2'b00, 4'h0, 4'hF, 8'h00, 8'h00);
      if (ob_rdy != 2'b00) begin
        chk("tie_grant", 32'(ob_rdy), 32'(exp_g));
        exp_g = ~exp_g;
      end
    end
    repeat (3) tick(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);

    // reset during a read's RDWAIT: no response afterwards, pointer back to favouring A
    tick(2'b01, 2'b00, 4'hF, 4'h0, 8'h00, 8'h00);
    tick(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'(2'b00));
    chk("midrst_rsp", 32'(bus.rsp_valid), 32'(2'b00));
    chk("midrst_busy", 32'(bus.busy), 32'(1'b0));
    chk("midrst_re", 32'(bus.mem_re), 32'(1'b0));
    @(posedge clk);
    #1;
    cyc++;
    chk("midrst_rsp_hold", 32'(bus.rsp_valid), 32'(2'b00));
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    model_reset();
    repeat (4) begin
      tick(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
      chk("post_rst_no_rsp", 32'(ob_rsp), 32'(2'b00));
    end
    tick(2'b11, 2'b00, 4'h0, 4'hF, 8'h00, 8'h00);
    chk("post_rst_tie", 32'(ob_rdy), 32'(2'b01));
    repeat (4) tick(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);

    // random traffic: each requester holds its request until accepted
    pv = 2'b00;
    pwe = 2'b00;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pv[i] && $urandom_range(0, 2) != 0) begin
          pv[i] = 1'b1;
          pwe[i] = 1'($urandom_range(0, 1));
          pa[i] = 4'($urandom_range(0, 15));
          pd[i] = 8'($urandom_range(0, 255));
        end
      tick(pv, pwe, pa[0], pa[1], pd[0], pd[1]);
      pv = pv & ~ob_rdy;
    end
    repeat (4) tick(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
